ysquare_bidir_lane_ctrl: RTL

// - Parametrised bidirectional pad controller; successor to the fixed 8-bit all-or-nothing uio steering.
// - Each lane has its own registered direction. A config handshake changes directions.
// - A bus-turnaround state machine guarantees a dead gap (oe low) on every lane that changes direction.
// - Inputs pass through a synchroniser and are reported with a change-detect valid pulse.
// - Sits between the tt_um top-level uio_* pins and core logic.
//

---
 rtl/ysquare_bidir_lane_ctrl.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/ysquare_bidir_lane_ctrl.sv
// Per-lane bidirectional pad controller with a dead-gap turnaround FSM and a synchronised input path.
// Optional feature: define LOOPBACK_EN to add lb_en (pad_out looped back into the synchroniser).
module ysquare_bidir_lane_ctrl #(
    parameter int WIDTH       = 8,
    parameter int TURN_CYCLES = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_dir,
    input  logic [WIDTH-1:0] tx_data,
    input  logic [WIDTH-1:0] pad_in,
`ifdef LOOPBACK_EN
    input  logic             lb_en,
`endif
    output logic [WIDTH-1:0] pad_out,
    output logic [WIDTH-1:0] pad_oe,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             busy
);

    typedef enum logic {ST_ACTIVE, ST_TURN} state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] dir_reg, dir_next;
    logic [WIDTH-1:0] pend_reg, pend_next;
    logic [WIDTH-1:0] mask_reg, mask_next;
    logic [3:0]       cnt_reg, cnt_next;

    logic [WIDTH-1:0] oe_next, out_next;
    logic [WIDTH-1:0] pad_oe_reg, pad_out_reg;
    logic [WIDTH-1:0] sync_in, sync_out, rx_next;
    logic [WIDTH-1:0] rx_reg, rx_prev_reg;
    logic             rx_valid_reg;
    logic [WIDTH-1:0] chg;
    logic             lb_on;

`ifdef LOOPBACK_EN
    assign lb_on = lb_en;
`else
    assign lb_on = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_ACTIVE;
            dir_reg   <= '0;
            pend_reg  <= '0;
            mask_reg  <= '0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            dir_reg   <= dir_next;
            pend_reg  <= pend_next;
            mask_reg  <= mask_next;
            cnt_reg   <= cnt_next;
        end
    end

    assign chg = dir_reg ^ cfg_dir;

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        dir_next   = dir_reg;
        pend_next  = pend_reg;
        mask_next  = mask_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ST_ACTIVE: begin
                if (cfg_valid && (chg != '0)) begin
                    pend_next  = cfg_dir;
                    mask_next  = chg;
                    cnt_next   = 4'(TURN_CYCLES);
                    state_next = ST_TURN;
                end
            end
            default: begin
                if (cnt_reg == 4'd1) begin
                    dir_next   = pend_reg;
                    mask_next  = '0;
                    state_next = ST_ACTIVE;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
        endcase
    end

    // Outputs are computed from the next state so a changing lane drops oe
    // on the very edge that accepts the new direction.
    always_comb begin
        cfg_ready = (state_reg == ST_ACTIVE);
        busy      = (state_reg == ST_TURN);
        out_next  = tx_data & dir_next & ~mask_next;
        oe_next   = lb_on ? '0 : (dir_next & ~mask_next);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pad_oe_reg  <= '0;
            pad_out_reg <= '0;
        end else begin
            pad_oe_reg  <= oe_next;
            pad_out_reg <= out_next;
        end
    end

    assign pad_oe  = pad_oe_reg;
    assign pad_out = pad_out_reg;

    assign sync_in = lb_on ? pad_out_reg : pad_in;

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : sync_gen
            logic [WIDTH-1:0] stage_reg;
            if (gi == 0) begin : g_first
                always_ff @(posedge clk) begin
                    if (rst) stage_reg <= '0;
                    else     stage_reg <= sync_in;
                end
            end else begin : g_rest
                always_ff @(posedge clk) begin
                    if (rst) stage_reg <= '0;
                    else     stage_reg <= sync_gen[gi-1].stage_reg;
                end
            end
        end
    endgenerate

    assign sync_out = sync_gen[SYNC_STAGES-1].stage_reg;
    assign rx_next  = lb_on ? sync_out : (sync_out & ~dir_reg);

    // rx_valid flags a change one cycle after rx_data shows it
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_reg       <= '0;
            rx_prev_reg  <= '0;
            rx_valid_reg <= 1'b0;
        end else begin
            rx_reg       <= rx_next;
            rx_prev_reg  <= rx_reg;
            rx_valid_reg <= (rx_reg != rx_prev_reg);
        end
    end

    assign rx_data  = rx_reg;
    assign rx_valid = rx_valid_reg;

endmodule
